fpmul_arb: RTL and testbench
============================

# fpmul_arb

Round-robin arbiter and sequencer that shares one `fpmul` instance among `NREQ` independent requesters. It latches the winning requester's operands and pulses `fpmul` Start. It then waits for Done, captures the product and the six exception flags, and returns them to the winner with a one-cycle acknowledge. It sits between the client logic and the single `fpmul` core; `fpmul` keeps its own ports unchanged.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `TIMEOUT`, 255, watchdog limit in cycles; used only when `FPMUL_ARB_TIMEOUT_EN` is defined
- `Clk` in 1: single clock; all state updates on the rising edge
- `Rst` in 1: synchronous, active-low reset
- `Req` in NREQ: per-requester request level
- `ReqA` in 32*NREQ: requester i operand A, at bits [32i+31:32i]
- `ReqB` in 32*NREQ: requester i operand B, same packing as `ReqA`
- `Ack` out NREQ: one-hot, one-cycle result-valid pulse to the granted requester
- `Gnt` out NREQ: one-hot, current owner of the multiplier; held from grant through `Ack`
- `Res_P` out 32: result product, valid while `Ack` is nonzero, held afterwards
- `Res_Flags` out 6: {UF, OF, NaNF, InfF, DNF, ZF}, captured with `Res_P`
- `Busy` out 1: high in any state other than IDLE
- `Err` out 1: timeout indication, pulses with `Ack`; tied 0 when the macro is not defined
- `M_Start` out 1: to `fpmul` Start; one-cycle pulse
- `M_A`, `M_B` out 32 each: to `fpmul` A and B; registered and held stable from ISSUE until the next grant
- `M_Done` in 1: from `fpmul` Done
- `M_P` in 32, `M_Flags` in 6: from `fpmul` P and {UF, OF, NaNF, InfF, DNF, ZF}

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If `Req` != 0, select the first set bit at or after `ptr`, searching cyclically.
  - Register `Gnt`, `M_A`, `M_B` from the winner's slices, then go to ISSUE.
  - If `Req` == 0, stay in IDLE.
- **ISSUE**
  - `M_Start`=1 for exactly this cycle.
  - Clear the watchdog counter, then go to WAIT.
- **WAIT**
  - `M_Done` is sampled only in WAIT. A Done that is high during ISSUE is ignored.
  - On `M_Done`=1: capture `M_P` into `Res_P` and `M_Flags` into `Res_Flags`, then go to RESP.
- **RESP**
  - `Ack` = `Gnt` for this cycle.
  - Set `ptr` = (winner+1) mod `NREQ`.
  - Clear `Gnt` and return to IDLE.
- `ptr` is log2(NREQ) bits wide and resets to 0. The winner is always the lowest index at or after `ptr`, modulo `NREQ`.
- A requester must hold `Req` and stable operands until it sees `Ack`. Its operands are sampled only in the IDLE→ISSUE cycle.
- A requester must drop `Req` in the cycle after `Ack`. A `Req` still high then is treated as a new request and arbitrated normally.
- **Req dropped mid-operation:** the operation still completes and `Ack` still pulses. No abort.
- **New Req asserted while Busy:** waits in the queue. It is considered at the next IDLE cycle.
- **Reset mid-operation:** on the next edge with `Rst`=0, the FSM goes to IDLE and all outputs and `ptr` go to zero.
  - The in-flight result is discarded and no `Ack` is issued.
  - `fpmul` must be reset in the same cycle by the top level.
- Reset values: `Ack`, `Gnt`, `Res_P`, `Res_Flags`, `Busy`, `Err`, `M_Start`, `M_A`, `M_B` all 0; state IDLE; `ptr` 0.

## Timing
- `Req` seen at edge 0 → grant registered, state ISSUE in cycle 1 (`M_Start`=1).
- `fpmul` Done seen at edge 2+L, where L = cycles from Start to Done → state RESP, with `Ack` high in cycle 3+L.
- End-to-end latency is 3+L cycles from sampled `Req` to `Ack`.
- Back-to-back throughput: one operation per 4+L cycles, because every operation passes through one IDLE cycle.
- Outputs are registered with no combinational input-to-output paths, except that `Ack` is decoded from the state register and `Gnt`.

## Configuration
- `FPMUL_ARB_TIMEOUT_EN` defined:
  - An 8–16-bit counter increments every WAIT cycle.
  - On reaching `TIMEOUT` with no `M_Done`, the FSM goes to RESP.
  - `Res_P` = 32'h7FC00000, `Res_Flags` = 6'b001000 (NaNF only), and `Err`=1 together with `Ack`.
  - `Done` arriving in the same cycle the limit is reached takes precedence: normal result, `Err`=0.
- Not defined: WAIT has no exit except `M_Done` or reset, and `Err` is constant 0.

## Test plan
- **Single request:** `Req`=0001, A=0x40000000 (2.0), B=0x40400000 (3.0).
  - `M_Start` pulses once in cycle 1.
  - `Ack`=0001 in cycle 3+L with `Res_P`=0x40C00000 and `Res_Flags`=0.
- **All four requesting continuously from reset:**
  - Grant order is 0,1,2,3,0.
  - Each `Ack` is spaced 4+L cycles apart.
  - `Gnt` is never more than one-hot.
- **Fairness:** `ptr`=2 with `Req`=1011 → requester 3 is granted first, then 0.
- **Flag passthrough:** A=0x7F800000, B=0x00000000 → `Res_Flags` NaNF=1, `Res_P` is the NaN produced by `fpmul`.
- **Reset mid-WAIT:** `Rst`=0 for one cycle during WAIT.
  - Next cycle: `Busy`=0, `Gnt`=0, no `Ack` for the aborted operation.
  - A subsequent request completes normally.
- **Timeout (macro defined):** `TIMEOUT`=10 with `M_Done` held 0 → `Ack` and `Err` in cycle 2+10+1, with `Res_P`=0x7FC00000.

Source files
------------

// File: rtl/fpmul_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : fpmul_arb_if
// Purpose  : Requester-side and fpmul-side signal bundle for fpmul_arb.
// Revision : 1.0 - initial release
// ============================================================================
interface fpmul_arb_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      Req;
    logic [32*NREQ-1:0]   ReqA;
    logic [32*NREQ-1:0]   ReqB;
    logic [NREQ-1:0]      Ack;
    logic [NREQ-1:0]      Gnt;
    logic [31:0]          Res_P;
    logic [5:0]           Res_Flags;
    logic                 Busy;
    logic                 Err;
    logic                 M_Start;
    logic [31:0]          M_A;
    logic [31:0]          M_B;
    logic                 M_Done;
    logic [31:0]          M_P;
    logic [5:0]           M_Flags;

    // Environment side: requesters plus the fpmul core results.
    modport master (
        output Req, ReqA, ReqB, M_Done, M_P, M_Flags,
        input  Ack, Gnt, Res_P, Res_Flags, Busy, Err, M_Start, M_A, M_B
    );

    // Arbiter side.
    modport slave (
        input  Req, ReqA, ReqB, M_Done, M_P, M_Flags,
        output Ack, Gnt, Res_P, Res_Flags, Busy, Err, M_Start, M_A, M_B
    );
endinterface
`default_nettype wire

// File: rtl/fpmul_arb.sv
`default_nettype none
// ============================================================================
// Module   : fpmul_arb
// Purpose  : Round-robin arbiter/sequencer sharing one fpmul core among NREQ
//            requesters. Optional watchdog: define FPMUL_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fpmul_arb #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  wire logic   Clk,
    input  wire logic   Rst,
    fpmul_arb_if.slave  bus
);
    localparam int          PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [31:0] c_QNAN  = 32'h7FC0_0000;
    localparam logic [5:0]  c_NANF  = 6'b001000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    generate
        if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
            $error("fpmul_arb: NREQ must be in 2..8");
        end
        if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
            $error("fpmul_arb: TIMEOUT must be in 1..65535");
        end
    endgenerate

    state_t             r_state;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_win;
    logic [NREQ-1:0]    r_gnt;
    logic [31:0]        r_m_a;
    logic [31:0]        r_m_b;
    logic [31:0]        r_res_p;
    logic [5:0]         r_res_flags;
    logic               r_busy;
    logic               r_start;
`ifdef FPMUL_ARB_TIMEOUT_EN
    logic [15:0]        r_wdog;
    logic               r_err;
`endif

    logic               w_found;
    logic [PW-1:0]      w_win;
    logic [PW-1:0]      w_cand;

    // Cyclic priority search starting at r_ptr; first hit wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = PW'((32'(r_ptr) + 32'(k)) % 32'(NREQ));
            if (!w_found && bus.Req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_win       <= '0;
            r_gnt       <= '0;
            r_m_a       <= '0;
            r_m_b       <= '0;
            r_res_p     <= '0;
            r_res_flags <= '0;
            r_busy      <= 1'b0;
            r_start     <= 1'b0;
`ifdef FPMUL_ARB_TIMEOUT_EN
            r_wdog      <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= NREQ'(1) << w_win;
                        r_win   <= w_win;
                        r_m_a   <= bus.ReqA[{w_win, 5'd0} +: 32];
                        r_m_b   <= bus.ReqB[{w_win, 5'd0} +: 32];
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_start <= 1'b0;
`ifdef FPMUL_ARB_TIMEOUT_EN
                    r_wdog  <= '0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Done wins over a watchdog expiry in the same cycle.
                    if (bus.M_Done) begin
                        r_res_p     <= bus.M_P;
                        r_res_flags <= bus.M_Flags;
`ifdef FPMUL_ARB_TIMEOUT_EN
                        r_err       <= 1'b0;
`endif
                        r_state     <= S_RESP;
                    end
`ifdef FPMUL_ARB_TIMEOUT_EN
                    else if (r_wdog == 16'(TIMEOUT)) begin
                        r_res_p     <= c_QNAN;
                        r_res_flags <= c_NANF;
                        r_err       <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_wdog      <= r_wdog + 16'd1;
                    end
`endif
                end
                S_RESP: begin
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
`ifdef FPMUL_ARB_TIMEOUT_EN
                    r_err   <= 1'b0;
`endif
                    r_ptr   <= (r_win == PW'(NREQ - 1)) ? '0 : r_win + 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.Ack       = (r_state == S_RESP) ? r_gnt : '0;
    assign bus.Gnt       = r_gnt;
    assign bus.Res_P     = r_res_p;
    assign bus.Res_Flags = r_res_flags;
    assign bus.Busy      = r_busy;
    assign bus.M_Start   = r_start;
    assign bus.M_A       = r_m_a;
    assign bus.M_B       = r_m_b;
`ifdef FPMUL_ARB_TIMEOUT_EN
    assign bus.Err       = r_err;
`else
    assign bus.Err       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpmul_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpmul_arb
// Purpose  : Directed self-checking bench for fpmul_arb with an fpmul stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpmul_arb;
    localparam int NREQ = 4;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_err;
    int   gnt_bad;
    int   start_cnt;
    int   mdl_lat;
    logic mdl_en;

    fpmul_arb_if #(.NREQ(NREQ)) bus ();

    fpmul_arb #(.NREQ(NREQ), .TIMEOUT(10)) dut (
        .Clk (clk),
        .Rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!$onehot0(bus.Gnt)) gnt_bad <= gnt_bad + 1;
        if (bus.M_Start === 1'b1) start_cnt <= start_cnt + 1;
    end

    function automatic logic [31:0] tag_a(input int i);
        return 32'h1000_0000 * 32'(i + 1) + 32'(i + 1);
    endfunction

    function automatic logic [31:0] tag_b(input int i);
        return 32'h0000_0100 << i;
    endfunction

    // fpmul stand-in: two exact products, otherwise an operand-tagged result.
    function automatic logic [37:0] stub_mul(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h4000_0000 && b == 32'h4040_0000) return {6'd0, 32'h40C0_0000};
        if (a == 32'h7F80_0000 && b == 32'h0000_0000) return {6'b001000, 32'h7FC0_0000};
        return {a[5:0] ^ b[5:0], a ^ b};
    endfunction

    // Done rises L+1 edges after the Start edge and is dropped if reset hits.
    initial begin : fpmul_model
        logic [31:0] a;
        logic [31:0] b;
        logic [37:0] r;
        logic        abort;
        bus.M_Done  = 1'b0;
        bus.M_P     = '0;
        bus.M_Flags = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.M_Start === 1'b1 && mdl_en) begin
                a = bus.M_A;
                b = bus.M_B;
                abort = 1'b0;
                for (int i = 0; i <= mdl_lat; i++) begin
                    @(posedge clk);
                    if (!rst_n) abort = 1'b1;
                end
                #1;
                if (!abort && rst_n) begin
                    r = stub_mul(a, b);
                    bus.M_P     = r[31:0];
                    bus.M_Flags = r[37:32];
                    bus.M_Done  = 1'b1;
                    @(posedge clk); #1;
                    bus.M_Done  = 1'b0;
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.ReqA[32*i +: 32] = a;
        bus.ReqB[32*i +: 32] = b;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && bus.Busy !== 1'b0; i++) @(negedge clk);
    endtask

    // Returns edges between the Req-sampling edge t0 and the Ack edge.
    task automatic wait_ack(input int t0, output int lat, output logic ok);
        ok  = 1'b0;
        lat = -1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.Ack !== '0) begin
                ok  = 1'b1;
                lat = cyc - t0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        bus.Req = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.Ack, bus.Gnt, bus.Busy, bus.Err, bus.M_Start} !== '0) begin
            n_err++;
            $display("FAIL reset_ctl: got Ack=%b Gnt=%b Busy=%b Err=%b Start=%b required all 0",
                     bus.Ack, bus.Gnt, bus.Busy, bus.Err, bus.M_Start);
        end
        n_cmp++;
        if ({bus.Res_P, bus.Res_Flags} !== '0) begin
            n_err++;
            $display("FAIL reset_res: got P=%h F=%b required 0", bus.Res_P, bus.Res_Flags);
        end
        n_cmp++;
        if ({bus.M_A, bus.M_B} !== '0) begin
            n_err++;
            $display("FAIL reset_ops: got A=%h B=%h required 0", bus.M_A, bus.M_B);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.Busy !== 1'b0 || bus.M_Start !== 1'b0) begin
            n_err++;
            $display("FAIL idle_no_req: got Busy=%b Start=%b required 0", bus.Busy, bus.M_Start);
        end
    endtask

    task automatic test_single();
        int   t0, lat, s0;
        logic ok;
        wait_idle();
        mdl_lat = 2;
        set_req(0, 32'h4000_0000, 32'h4040_0000);
        bus.Req = 4'b0001;
        s0 = start_cnt;
        t0 = cyc + 1;
        @(negedge clk);
        n_cmp++;
        if (bus.M_Start !== 1'b1 || bus.Gnt !== 4'b0001 || bus.Busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_issue: got Start=%b Gnt=%b Busy=%b required 1/0001/1",
                     bus.M_Start, bus.Gnt, bus.Busy);
        end
        n_cmp++;
        if (bus.M_A !== 32'h4000_0000 || bus.M_B !== 32'h4040_0000) begin
            n_err++;
            $display("FAIL single_ops: got A=%h B=%h required 40000000/40400000", bus.M_A, bus.M_B);
        end
        wait_ack(t0, lat, ok);
        n_cmp++;
        if (!ok || lat !== mdl_lat + 2) begin
            n_err++;
            $display("FAIL single_latency: got ok=%b lat=%0d required lat=%0d", ok, lat, mdl_lat + 2);
        end
        n_cmp++;
        if (bus.Ack !== 4'b0001 || bus.Err !== 1'b0) begin
            n_err++;
            $display("FAIL single_ack: got Ack=%b Err=%b required 0001/0", bus.Ack, bus.Err);
        end
        n_cmp++;
        if (bus.Res_P !== 32'h40C0_0000 || bus.Res_Flags !== 6'd0) begin
            n_err++;
            $display("FAIL single_result: got P=%h F=%b required 40c00000/000000", bus.Res_P, bus.Res_Flags);
        end
        n_cmp++;
        if (start_cnt - s0 !== 1) begin
            n_err++;
            $display("FAIL single_start_count: got %0d required 1", start_cnt - s0);
        end
        bus.Req = '0;
        @(negedge clk);
        n_cmp++;
        if (bus.Ack !== '0 || bus.Gnt !== '0 || bus.M_A !== 32'h4000_0000 || bus.Res_P !== 32'h40C0_0000) begin
            n_err++;
            $display("FAIL single_after: got Ack=%b Gnt=%b A=%h P=%h required 0/0/40000000/40c00000",
                     bus.Ack, bus.Gnt, bus.M_A, bus.Res_P);
        end
    endtask

    task automatic test_round_robin();
        int   t0, lat, prev, now, exp_i;
        logic ok;
        rst_n   = 1'b0;
        mdl_lat = 1;
        for (int i = 0; i < NREQ; i++) set_req(i, tag_a(i), tag_b(i));
        bus.Req = 4'b1111;
        repeat (2) @(negedge clk);
        gnt_bad = 0;
        rst_n = 1'b1;
        t0    = cyc + 1;
        prev  = t0;
        for (int n = 0; n < 5; n++) begin
            exp_i = n % NREQ;
            wait_ack(t0, lat, ok);
            now = t0 + lat;
            if (n == 4) bus.Req = '0;
            n_cmp++;
            if (!ok || bus.Ack !== 4'(1 << exp_i)) begin
                n_err++;
                $display("FAIL rr_order[%0d]: got ok=%b Ack=%b required %b", n, ok, bus.Ack, 4'(1 << exp_i));
                return;
            end
            n_cmp++;
            if (bus.Res_P !== (tag_a(exp_i) ^ tag_b(exp_i)) || bus.Res_Flags !== 6'(exp_i + 1)) begin
                n_err++;
                $display("FAIL rr_result[%0d]: got P=%h F=%b required %h/%b", n, bus.Res_P, bus.Res_Flags,
                         tag_a(exp_i) ^ tag_b(exp_i), 6'(exp_i + 1));
            end
            n_cmp++;
            if (now - prev !== ((n == 0) ? mdl_lat + 2 : mdl_lat + 4)) begin
                n_err++;
                $display("FAIL rr_spacing[%0d]: got %0d required %0d", n, now - prev,
                         (n == 0) ? mdl_lat + 2 : mdl_lat + 4);
            end
            prev = now;
        end
        n_cmp++;
        if (gnt_bad !== 0) begin
            n_err++;
            $display("FAIL rr_gnt_onehot: got %0d violations required 0", gnt_bad);
        end
    endtask

    task automatic test_fairness();
        int   t0, lat;
        logic ok;
        wait_idle();
        mdl_lat = 1;
        bus.Req = 4'b0010;
        t0 = cyc + 1;
        wait_ack(t0, lat, ok);
        bus.Req = '0;
        n_cmp++;
        if (!ok || bus.Ack !== 4'b0010) begin
            n_err++;
            $display("FAIL fair_setup: got ok=%b Ack=%b required 0010", ok, bus.Ack);
        end
        @(negedge clk);
        // pointer now sits at 2; requester 3 must beat 0 and 1
        bus.Req = 4'b1011;
        t0 = cyc + 1;
        wait_ack(t0, lat, ok);
        n_cmp++;
        if (!ok || bus.Ack !== 4'b1000 || bus.Res_P !== (tag_a(3) ^ tag_b(3))) begin
            n_err++;
            $display("FAIL fair_first: got ok=%b Ack=%b P=%h required 1000/%h", ok, bus.Ack, bus.Res_P,
                     tag_a(3) ^ tag_b(3));
        end
        bus.Req = 4'b0011;
        wait_ack(t0, lat, ok);
        bus.Req = '0;
        n_cmp++;
        if (!ok || bus.Ack !== 4'b0001 || bus.Res_P !== (tag_a(0) ^ tag_b(0))) begin
            n_err++;
            $display("FAIL fair_second: got ok=%b Ack=%b P=%h required 0001/%h", ok, bus.Ack, bus.Res_P,
                     tag_a(0) ^ tag_b(0));
        end
    endtask

    task automatic test_flags();
        int   t0, lat;
        logic ok;
        @(negedge clk);
        wait_idle();
        mdl_lat = 3;
        set_req(2, 32'h7F80_0000, 32'h0000_0000);
        bus.Req = 4'b0100;
        t0 = cyc + 1;
        wait_ack(t0, lat, ok);
        bus.Req = '0;
        n_cmp++;
        if (!ok || bus.Ack !== 4'b0100 || lat !== mdl_lat + 2) begin
            n_err++;
            $display("FAIL flags_ack: got ok=%b Ack=%b lat=%0d required 0100/%0d", ok, bus.Ack, lat, mdl_lat + 2);
        end
        n_cmp++;
        if (bus.Res_Flags !== 6'b001000 || bus.Res_P !== 32'h7FC0_0000) begin
            n_err++;
            $display("FAIL flags_nan: got P=%h F=%b required 7fc00000/001000", bus.Res_P, bus.Res_Flags);
        end
    endtask

    task automatic test_reset_mid_wait();
        int   t0, lat, acks;
        logic ok;
        @(negedge clk);
        wait_idle();
        mdl_lat = 8;
        for (int i = 0; i < NREQ; i++) set_req(i, tag_a(i), tag_b(i));
        bus.Req = 4'b0100;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (bus.Busy !== 1'b1 || bus.Gnt !== 4'b0100) begin
            n_err++;
            $display("FAIL midrst_pre: got Busy=%b Gnt=%b required 1/0100", bus.Busy, bus.Gnt);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        bus.Req = '0;
        n_cmp++;
        if (bus.Busy !== 1'b0 || bus.Gnt !== '0 || bus.Ack !== '0 || bus.M_A !== '0 || bus.M_Start !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_state: got Busy=%b Gnt=%b Ack=%b A=%h Start=%b required all 0",
                     bus.Busy, bus.Gnt, bus.Ack, bus.M_A, bus.M_Start);
        end
        acks = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.Ack !== '0) acks++;
        end
        n_cmp++;
        if (acks !== 0) begin
            n_err++;
            $display("FAIL midrst_no_ack: got %0d acks required 0", acks);
        end
        mdl_lat = 2;
        bus.Req = 4'b1100;
        t0 = cyc + 1;
        wait_ack(t0, lat, ok);
        bus.Req = '0;
        n_cmp++;
        if (!ok || bus.Ack !== 4'b0100 || lat !== mdl_lat + 2) begin
            n_err++;
            $display("FAIL midrst_after: got ok=%b Ack=%b lat=%0d required 0100/%0d", ok, bus.Ack, lat, mdl_lat + 2);
        end
        n_cmp++;
        if (bus.Res_P !== (tag_a(2) ^ tag_b(2)) || bus.Res_Flags !== 6'd3) begin
            n_err++;
            $display("FAIL midrst_result: got P=%h F=%b required %h/000011", bus.Res_P, bus.Res_Flags,
                     tag_a(2) ^ tag_b(2));
        end
    endtask

`ifdef FPMUL_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int   t0, lat;
        logic ok;
        @(negedge clk);
        wait_idle();
        mdl_en  = 1'b0;
        bus.Req = 4'b0001;
        t0 = cyc + 1;
        wait_ack(t0, lat, ok);
        bus.Req = '0;
        n_cmp++;
        if (!ok || bus.Ack !== 4'b0001 || lat !== 12) begin
            n_err++;
            $display("FAIL timeout_ack: got ok=%b Ack=%b lat=%0d required 0001/12", ok, bus.Ack, lat);
        end
        n_cmp++;
        if (bus.Err !== 1'b1 || bus.Res_P !== 32'h7FC0_0000 || bus.Res_Flags !== 6'b001000) begin
            n_err++;
            $display("FAIL timeout_res: got Err=%b P=%h F=%b required 1/7fc00000/001000",
                     bus.Err, bus.Res_P, bus.Res_Flags);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.Err !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_err_pulse: got Err=%b required 0", bus.Err);
        end
        mdl_en = 1'b1;
    endtask
`endif

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        mdl_lat   = 1;
        mdl_en    = 1'b1;
        bus.Req   = '0;
        bus.ReqA  = '0;
        bus.ReqB  = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_flags();
        test_reset_mid_wait();
`ifdef FPMUL_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        cyc       = 0;
        gnt_bad   = 0;
        start_cnt = 0;
    end

endmodule
`default_nettype wire
